// File: rtl/zap_regf_wr_arbiter_if.sv
// Register-file write arbiter bundle: exception, pipeline and coprocessor requests plus
// the registered write-port outputs that feed the BRAM register file.
interface zap_regf_wr_arbiter_if #(
   parameter int unsigned IW = 6
);
   logic          exc_req;
   logic [IW-1:0] exc_lr_idx;
   logic [31:0]   exc_lr_data;
   logic [IW-1:0] exc_spsr_idx;
   logic [31:0]   exc_spsr_data;

   logic          wb_valid;
   logic          wb_ready;
   logic [IW-1:0] wb_idx0;
   logic [31:0]   wb_data0;
   logic          wb_idx1_en;
   logic [IW-1:0] wb_idx1;
   logic [31:0]   wb_data1;

   logic          cp_valid;
   logic          cp_ready;
   logic [IW-1:0] cp_idx;
   logic [31:0]   cp_data;

   logic [IW-1:0] wa1;
   logic [IW-1:0] wa2;
   logic [31:0]   wdata1;
   logic [31:0]   wdata2;
   logic          wen;
   logic          cp_busy;

   modport master (
      output exc_req, exc_lr_idx, exc_lr_data, exc_spsr_idx, exc_spsr_data,
      output wb_valid, wb_idx0, wb_data0, wb_idx1_en, wb_idx1, wb_data1,
      output cp_valid, cp_idx, cp_data,
      input  wb_ready, cp_ready, wa1, wa2, wdata1, wdata2, wen, cp_busy
   );

   modport slave (
      input  exc_req, exc_lr_idx, exc_lr_data, exc_spsr_idx, exc_spsr_data,
      input  wb_valid, wb_idx0, wb_data0, wb_idx1_en, wb_idx1, wb_data1,
      input  cp_valid, cp_idx, cp_data,
      output wb_ready, cp_ready, wa1, wa2, wdata1, wdata2, wen, cp_busy
   );
endinterface

// File: rtl/zap_regf_wr_arbiter.sv
// Arbitrates the two register-file write ports between exception entry, pipeline
// writeback and a buffered coprocessor write FIFO with a starvation guard.
module zap_regf_wr_arbiter #(
   parameter int unsigned PHY_REGS      = 46,
   parameter int unsigned RAZ_IDX       = 45,
   parameter int unsigned CP_FIFO_DEPTH = 4,
   parameter int unsigned STARVE_LIMIT  = 8
) (
   input logic                  i_clk,
   input logic                  i_reset_n,
   zap_regf_wr_arbiter_if.slave bus
);
   localparam int unsigned IW   = $clog2(PHY_REGS);
   localparam int unsigned PW   = $clog2(CP_FIFO_DEPTH);
   localparam int unsigned IW_F = PW + 1;
   localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

   localparam logic [IW-1:0]   RAZ        = IW'(RAZ_IDX);
   localparam logic [IW_F-1:0] FULL_CNT   = IW_F'(CP_FIFO_DEPTH);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   logic [IW-1:0]   fifo_idx  [CP_FIFO_DEPTH];
   logic [31:0]     fifo_data [CP_FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [IW_F-1:0] count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;

   logic [IW-1:0]   wa1_q, wa1_d, wa2_q, wa2_d;
   logic [31:0]     wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic            wen_q, wen_d;
   logic            cp_out_q;

   logic            fifo_empty, fifo_full;
   logic            starve_hit, enq, drain, wb_ready;
   logic [IW-1:0]   head_idx;
   logic [31:0]     head_data;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign head_idx   = fifo_idx[rd_ptr_q];
   assign head_data  = fifo_data[rd_ptr_q];
   assign starve_hit = (starve_q == STARVE_MAX) && !fifo_empty;
   // Full is judged on the registered count, so a same-cycle drain never frees a slot early.
   assign enq        = bus.cp_valid && !fifo_full;

   always_comb begin
      wa1_d    = RAZ;
      wa2_d    = RAZ;
      wdata1_d = '0;
      wdata2_d = '0;
      wen_d    = 1'b0;
      drain    = 1'b0;
      wb_ready = 1'b1;
      if (bus.exc_req) begin
         wb_ready = 1'b0;
         wa1_d    = bus.exc_lr_idx;
         wdata1_d = bus.exc_lr_data;
         wa2_d    = bus.exc_spsr_idx;
         wdata2_d = bus.exc_spsr_data;
         wen_d    = 1'b1;
      end else if (starve_hit) begin
         wb_ready = 1'b0;
         wa1_d    = head_idx;
         wdata1_d = head_data;
         wen_d    = 1'b1;
         drain    = 1'b1;
      end else if (bus.wb_valid) begin
         wa1_d    = bus.wb_idx0;
         wdata1_d = bus.wb_data0;
         wen_d    = 1'b1;
         if (bus.wb_idx1_en) begin
            wa2_d    = bus.wb_idx1;
            wdata2_d = bus.wb_data1;
         end else if (!fifo_empty && (head_idx != bus.wb_idx0)) begin
            // Port B is free; piggyback the CP head unless it would collide with port A.
            wa2_d    = head_idx;
            wdata2_d = head_data;
            drain    = 1'b1;
         end
      end else if (!fifo_empty) begin
         wa1_d    = head_idx;
         wdata1_d = head_data;
         wen_d    = 1'b1;
         drain    = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;
      if (enq) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (drain) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (!bus.exc_req) begin
         if (drain || fifo_empty) begin
            starve_d = '0;
         end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         wa1_q    <= RAZ;
         wa2_q    <= RAZ;
         wdata1_q <= '0;
         wdata2_q <= '0;
         wen_q    <= 1'b0;
         cp_out_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         wa1_q    <= wa1_d;
         wa2_q    <= wa2_d;
         wdata1_q <= wdata1_d;
         wdata2_q <= wdata2_d;
         wen_q    <= wen_d;
         cp_out_q <= drain;
      end
   end

   // Storage needs no reset: entries are only read when count says they are valid.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         fifo_idx[wr_ptr_q]  <= bus.cp_idx;
         fifo_data[wr_ptr_q] <= bus.cp_data;
      end
   end

   assign bus.wb_ready = wb_ready;
   assign bus.cp_ready = !fifo_full;
   assign bus.wa1      = wa1_q;
   assign bus.wa2      = wa2_q;
   assign bus.wdata1   = wdata1_q;
   assign bus.wdata2   = wdata2_q;
   assign bus.wen      = wen_q;
   assign bus.cp_busy  = (count_q != '0) || cp_out_q;
endmodule
